// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core job sequencer.
// Register file layout: A occupies addresses 31..16, B occupies 15..0, element k counts downward.
package tensor_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_DONE,
    ST_SETTLE,
    ST_DRAIN
  } tc_state_e;

  localparam int MATRIX_DIM    = 4;
  localparam int ELEMS         = MATRIX_DIM * MATRIX_DIM;
  localparam int OPERAND_BYTES = 2 * ELEMS;
  localparam int A_BASE_ADDR   = 31;
  localparam int B_BASE_ADDR   = 15;

  function automatic logic [4:0] tc_reg_addr(input logic is_b, input logic [3:0] k);
    logic [4:0] base;
    base = is_b ? 5'(B_BASE_ADDR) : 5'(A_BASE_ADDR);
    return base - {1'b0, k};
  endfunction

endpackage

// File: rtl/tensor_core_sequencer.sv
// Sequences one 4x4 int8 matrix-multiply job: load 32 operand bytes into the
// register file, kick the core, wait for completion (with timeout), drain 16 results.
module tensor_core_sequencer
  import tensor_core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic         clock_in,
  input  logic         reset_in,
  input  logic         start_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         error_out,
  input  logic         operand_valid_in,
  input  logic [7:0]   operand_data_in,
  output logic         operand_ready_out,
  output logic         result_valid_out,
  output logic [7:0]   result_data_out,
  input  logic         result_ready_in,
  output logic         tc_write_enable_out,
  output logic [4:0]   tc_write_address_out,
  output logic [7:0]   tc_write_data_out,
  output logic         tc_kick_out,
  input  logic         tc_done_in,
  input  logic [255:0] tc_read_data_in
);

  tc_state_e                state_q, state_d;
  logic [4:0]               idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     error_q, error_d;
  logic                     done_q, done_d;
  logic                     kick_q, kick_d;
  logic                     we_q, we_d;
  logic [4:0]               waddr_q, waddr_d;
  logic [7:0]               wdata_q, wdata_d;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      kick_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      done_q  <= done_d;
      kick_q  <= kick_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Both streams transfer a byte on a cycle where valid and ready are high together;
  // ready/valid depend only on state, and the producer must hold data while stalled.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    done_d  = 1'b0;
    kick_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (operand_valid_in) begin
          we_d    = 1'b1;
          waddr_d = tc_reg_addr(idx_q[4], idx_q[3:0]);
          wdata_d = operand_data_in;
          idx_d   = idx_q + 5'd1;
          if (idx_q == 5'(OPERAND_BYTES - 1)) state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        kick_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (tc_done_in) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        idx_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (result_ready_in) begin
          idx_d = idx_q + 5'd1;
          if (idx_q[3:0] == 4'(ELEMS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result byte k sits at bits [255-8k -: 8], i.e. lsb index 8*(31-k) = {1, ~k, 000}.
  always_comb begin
    busy_out          = (state_q != ST_IDLE);
    operand_ready_out = (state_q == ST_LOAD);
    result_valid_out  = (state_q == ST_DRAIN);
    result_data_out   = '0;
    if (state_q == ST_DRAIN) result_data_out = tc_read_data_in[{1'b1, ~idx_q[3:0], 3'b000} +: 8];
  end

  assign done_out             = done_q;
  assign error_out            = error_q;
  assign tc_kick_out          = kick_q;
  assign tc_write_enable_out  = we_q;
  assign tc_write_address_out = waddr_q;
  assign tc_write_data_out    = wdata_q;

endmodule
